pipeline_hazard_controller: RTL and testbench

//   Central stall/flush sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB). Sits beside the four

---
 rtl/pipeline_hazard_controller.sv | 111 +++++++++++
 tb/tb_pipeline_hazard_controller.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush/PC-write sequencer for a 5-stage pipeline
// covering load-use, redirects, memory wait states and HLT drain, plus a lost-cycle counter.
module pipeline_hazard_controller #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       rs_ID,
   input  logic [1:0]       rt_ID,
   input  logic             use_rs_ID,
   input  logic             use_rt_ID,
   input  logic             d_readM_EX,
   input  logic             RegWrite_EX,
   input  logic [1:0]       write_reg_addr_EX,
   input  logic             jump_ID,
   input  logic             mispredict_EX,
   input  logic             is_halted_MEM,
   input  logic             i_mem_ready,
   input  logic             d_mem_req_MEM,
   input  logic             d_mem_ready,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             i_abort,
   output logic             stall_IF_ID,
   output logic             stall_ID_EX,
   output logic             stall_EX_MEM,
   output logic             stall_MEM_WB,
   output logic             flush_IF_ID,
   output logic             flush_ID_EX,
   output logic             flush_EX_MEM,
   output logic             flush_MEM_WB,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cycles
);
   typedef enum logic [2:0] {RUN, IWAIT, DWAIT, DRAIN, HALT} state_t;
   state_t           r_state, w_next;
   logic [CNT_W-1:0] r_cnt;
   logic             w_dhz, w_lu, w_ihz, w_pc_write, w_i_abort, w_halted;
   logic [1:0]       w_pc_src;
   logic [3:0]       w_stall, w_flush;
   assign w_dhz = d_mem_req_MEM & ~d_mem_ready;
   assign w_lu  = d_readM_EX & RegWrite_EX &
                  ((use_rs_ID & (rs_ID == write_reg_addr_EX)) | (use_rt_ID & (rt_ID == write_reg_addr_EX)));
   assign w_ihz = ~i_mem_ready;
   // Stall/flush vectors are ordered {IF_ID, ID_EX, EX_MEM, MEM_WB}.
   always_comb begin
      w_next     = RUN;
      w_pc_write = 1'b1;
      w_pc_src   = 2'd0;
      w_i_abort  = 1'b0;
      w_halted   = 1'b0;
      w_stall    = 4'b0000;
      w_flush    = 4'b0000;
      if (r_state == HALT) begin
         w_next     = HALT;
         w_pc_write = 1'b0;
         w_halted   = 1'b1;
         w_stall    = 4'b1111;
      end else if (r_state == DRAIN) begin
         w_next     = HALT;
         w_pc_write = 1'b0;
         w_stall    = 4'b1110;
         w_flush    = 4'b0001;
      end else if (w_dhz) begin
         w_next     = DWAIT;
         w_pc_write = 1'b0;
         w_stall    = 4'b1110;
         w_flush    = 4'b0001;
      end else if (is_halted_MEM) begin
         w_next     = DRAIN;
         w_pc_write = 1'b0;
         w_i_abort  = 1'b1;
         w_stall    = 4'b1100;
         w_flush    = 4'b0010;
      end else if (mispredict_EX) begin
         w_pc_src  = 2'd2;
         w_i_abort = w_ihz;
         w_flush   = 4'b1100;
      end else if (w_lu) begin
         w_next     = w_ihz ? IWAIT : RUN;
         w_pc_write = 1'b0;
         w_stall    = 4'b1000;
         w_flush    = 4'b0100;
      end else if (jump_ID) begin
         w_pc_src  = 2'd1;
         w_i_abort = w_ihz;
         w_flush   = 4'b1000;
      end else if (w_ihz) begin
         w_next     = IWAIT;
         w_pc_write = 1'b0;
         w_flush    = 4'b1000;
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (!w_pc_write && r_state != HALT && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      end
   end
   // Reset forces bubbles everywhere regardless of the registered state.
   assign pc_write     = reset_n & w_pc_write;
   assign pc_src       = reset_n ? w_pc_src : 2'd0;
   assign i_abort      = reset_n & w_i_abort;
   assign halted       = reset_n & w_halted;
   assign {stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB} = reset_n ? w_stall : 4'b0000;
   assign {flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB} = reset_n ? w_flush : 4'b1111;
   assign stall_cycles = r_cnt;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed vectors with hand-computed expected control outputs.
module tb_pipeline_hazard_controller;
   localparam logic [12:0] NORM = 13'b1_00_0_0000_0000_0;
   localparam logic [12:0] RST  = 13'b0_00_0_0000_1111_0;
   localparam logic [12:0] DW   = 13'b0_00_0_1110_0001_0;
   localparam logic [12:0] LUO  = 13'b0_00_0_1000_0100_0;
   localparam logic [12:0] IW   = 13'b0_00_0_0000_1000_0;
   localparam logic [12:0] HM   = 13'b0_00_1_1100_0010_0;
   localparam logic [12:0] HLTO = 13'b0_00_0_1111_0000_1;
   localparam logic [12:0] MP   = 13'b1_10_0_0000_1100_0;
   localparam logic [12:0] MPA  = 13'b1_10_1_0000_1100_0;
   localparam logic [12:0] JA   = 13'b1_01_1_0000_1000_0;
   logic clk = 1'b0, reset_n;
   logic [1:0] rs_ID, rt_ID, write_reg_addr_EX, pc_src;
   logic use_rs_ID, use_rt_ID, d_readM_EX, RegWrite_EX, jump_ID, mispredict_EX, is_halted_MEM;
   logic i_mem_ready, d_mem_req_MEM, d_mem_ready, pc_write, i_abort, halted;
   logic stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB;
   logic flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB;
   logic [3:0] stall_cycles;
   logic [12:0] w_o;
   logic store_ex;
   int n_chk, n_fail, writes;
   pipeline_hazard_controller #(.CNT_W(4)) dut (
      .clk(clk), .reset_n(reset_n), .rs_ID(rs_ID), .rt_ID(rt_ID), .use_rs_ID(use_rs_ID),
      .use_rt_ID(use_rt_ID), .d_readM_EX(d_readM_EX), .RegWrite_EX(RegWrite_EX),
      .write_reg_addr_EX(write_reg_addr_EX), .jump_ID(jump_ID), .mispredict_EX(mispredict_EX),
      .is_halted_MEM(is_halted_MEM), .i_mem_ready(i_mem_ready), .d_mem_req_MEM(d_mem_req_MEM),
      .d_mem_ready(d_mem_ready), .pc_write(pc_write), .pc_src(pc_src), .i_abort(i_abort),
      .stall_IF_ID(stall_IF_ID), .stall_ID_EX(stall_ID_EX), .stall_EX_MEM(stall_EX_MEM),
      .stall_MEM_WB(stall_MEM_WB), .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
      .flush_EX_MEM(flush_EX_MEM), .flush_MEM_WB(flush_MEM_WB), .halted(halted),
      .stall_cycles(stall_cycles)
   );
   always #5 clk = ~clk;
   assign w_o = {pc_write, pc_src, i_abort, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB,
                 flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB, halted};
   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask
   task automatic idle();
      rs_ID = 2'd0; rt_ID = 2'd0; write_reg_addr_EX = 2'd0;
      use_rs_ID = 1'b0; use_rt_ID = 1'b0; d_readM_EX = 1'b0; RegWrite_EX = 1'b0;
      jump_ID = 1'b0; mispredict_EX = 1'b0; is_halted_MEM = 1'b0;
      i_mem_ready = 1'b1; d_mem_req_MEM = 1'b0; d_mem_ready = 1'b0;
   endtask
   // Store sitting in EX commits at the edge unless flushed or held.
   task automatic cyc();
      if (store_ex) begin
         if (flush_EX_MEM) store_ex = 1'b0;
         else if (!stall_EX_MEM) begin
            writes++;
            store_ex = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask
   initial begin
      n_chk = 0; n_fail = 0; writes = 0; store_ex = 1'b0;
      idle();
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      #1 chk("rst_out", 16'(w_o), 16'(RST));
      chk("rst_cnt", 16'(stall_cycles), 16'd0);
      d_mem_req_MEM = 1'b1;
      #1 chk("rst_dhz", 16'(w_o), 16'(RST));
      idle();
      @(posedge clk);
      #1 reset_n = 1'b1;
      #1 chk("run_idle", 16'(w_o), 16'(NORM));
      cyc();
      d_readM_EX = 1'b1; RegWrite_EX = 1'b1; write_reg_addr_EX = 2'd1; rs_ID = 2'd1; use_rs_ID = 1'b1;
      #1 chk("lu_rs", 16'(w_o), 16'(LUO));
      cyc();
      idle();
      #1 chk("lu_after", 16'(w_o), 16'(NORM));
      chk("lu_cnt", 16'(stall_cycles), 16'd1);
      d_readM_EX = 1'b1; RegWrite_EX = 1'b1; write_reg_addr_EX = 2'd2; rt_ID = 2'd2; use_rt_ID = 1'b1;
      use_rs_ID = 1'b1;
      #1 chk("lu_rt", 16'(w_o), 16'(LUO));
      use_rt_ID = 1'b0;
      #1 chk("lu_nouse", 16'(w_o), 16'(NORM));
      use_rt_ID = 1'b1; RegWrite_EX = 1'b0;
      #1 chk("lu_nowr", 16'(w_o), 16'(NORM));
      RegWrite_EX = 1'b1; mispredict_EX = 1'b1;
      #1 chk("mp_lu", 16'(w_o), 16'(MP));
      i_mem_ready = 1'b0;
      #1 chk("mp_ihz", 16'(w_o), 16'(MPA));
      jump_ID = 1'b1;
      #1 chk("mp_over_jmp", 16'(w_o), 16'(MPA));
      cyc();
      idle();
      #1 chk("mp_next", 16'(w_o), 16'(NORM));
      chk("mp_cnt", 16'(stall_cycles), 16'd1);
      d_mem_req_MEM = 1'b1; is_halted_MEM = 1'b1;
      #1 chk("dhz_over_hlt", 16'(w_o), 16'(DW));
      is_halted_MEM = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1 chk("dwait", 16'(w_o), 16'(DW));
         cyc();
      end
      d_mem_ready = 1'b1;
      #1 chk("dwait_rel", 16'(w_o), 16'(NORM));
      cyc();
      idle();
      chk("dwait_cnt", 16'(stall_cycles), 16'd4);
      i_mem_ready = 1'b0;
      #1 chk("iwait_0", 16'(w_o), 16'(IW));
      cyc();
      #1 chk("iwait_1", 16'(w_o), 16'(IW));
      cyc();
      jump_ID = 1'b1;
      #1 chk("jmp_iwait", 16'(w_o), 16'(JA));
      cyc();
      idle();
      #1 chk("iwait_exit", 16'(w_o), 16'(NORM));
      chk("iwait_cnt", 16'(stall_cycles), 16'd6);
      store_ex = 1'b1; is_halted_MEM = 1'b1;
      #1 chk("hlt_mem", 16'(w_o), 16'(HM));
      cyc();
      is_halted_MEM = 1'b0; mispredict_EX = 1'b1;
      #1 chk("drain", 16'(w_o), 16'(DW));
      cyc();
      idle();
      #1 chk("halt", 16'(w_o), 16'(HLTO));
      cyc();
      d_mem_req_MEM = 1'b1; i_mem_ready = 1'b0;
      #1 chk("halt_sticky", 16'(w_o), 16'(HLTO));
      cyc();
      cyc();
      chk("halt_cnt", 16'(stall_cycles), 16'd8);
      chk("st_writes", 16'(writes), 16'd0);
      idle();
      reset_n = 1'b0;
      #1 chk("rst_halt", 16'(w_o), 16'(RST));
      chk("rst_halt_cnt", 16'(stall_cycles), 16'd0);
      cyc();
      reset_n = 1'b1;
      #1 chk("run_after_halt", 16'(w_o), 16'(NORM));
      d_mem_req_MEM = 1'b1;
      cyc();
      #1 chk("dwait_pre", 16'(w_o), 16'(DW));
      chk("dwait_pre_cnt", 16'(stall_cycles), 16'd1);
      #1 reset_n = 1'b0;
      #1 chk("rst_mid_dwait", 16'(w_o), 16'(RST));
      chk("rst_mid_cnt", 16'(stall_cycles), 16'd0);
      cyc();
      idle();
      reset_n = 1'b1;
      #1 chk("run_after_dw", 16'(w_o), 16'(NORM));
      cyc();
      chk("cnt_after_dw", 16'(stall_cycles), 16'd0);
      d_mem_req_MEM = 1'b1;
      repeat (20) cyc();
      chk("cnt_sat", 16'(stall_cycles), 16'd15);
      chk("dwait_long", 16'(w_o), 16'(DW));
      idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
